// File: rtl/wb_stage.sv
// wb_stage: RV32 writeback stage with a single-entry pending-load buffer.
// Optional load-response timeout is built when WB_LOAD_TIMEOUT_EN is defined.
module wb_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic [4:0]      wb_rd_i,
    input  logic            wb_reg_write_i,
    input  logic [XLEN-1:0] wb_result_i,
    input  logic            wb_is_load_i,
    input  logic [2:0]      wb_funct3_i,
    input  logic [1:0]      wb_addr_lsb_i,
    input  logic            lsu_rvalid_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rd_din_o,
    output logic            reg_write_o,
    output logic            load_pending_o,
    output logic [4:0]      load_rd_o,
    output logic            load_err_o,
    output logic            spurious_o,
    output logic [31:0]     retire_cnt_o
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [4:0] pend_rd_q;
    logic [2:0] pend_f3_q;
    logic [1:0] pend_lsb_q;
    logic       pend_we_q;

    logic            accept;
    logic            load_done;
    logic            timeout;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;
    logic            retire;
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign wb_ready_o     = (state_q == IDLE);
    assign load_pending_o = (state_q == LOAD_WAIT);
    assign load_rd_o      = load_pending_o ? pend_rd_q : 5'd0;
    assign accept         = wb_valid_i && wb_ready_o;
    assign load_done      = (state_q == LOAD_WAIT) && lsu_rvalid_i;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_q;

    assign timeout = (state_q == LOAD_WAIT) && !lsu_rvalid_i
                     && (tmo_cnt_q == TMO);

    // Count LOAD_WAIT cycles spent without a response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= 8'd0;
        end else if (accept && wb_is_load_i) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == LOAD_WAIT && !lsu_rvalid_i
                     && tmo_cnt_q != TMO) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end
`else
    logic unused_tmo;

    assign timeout    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic: a load parks the stage until response or timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && wb_is_load_i) state_d = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                if (lsu_rvalid_i || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Pending-load buffer captured on load acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_rd_q  <= 5'd0;
            pend_f3_q  <= 3'd0;
            pend_lsb_q <= 2'd0;
            pend_we_q  <= 1'b0;
        end else if (accept && wb_is_load_i) begin
            pend_rd_q  <= wb_rd_i;
            pend_f3_q  <= wb_funct3_i;
            pend_lsb_q <= wb_addr_lsb_i;
            pend_we_q  <= wb_reg_write_i;
        end
    end

    // Byte/halfword extraction with sign or zero extension
    always_comb begin
        byte_sh = lsu_rdata_i >> {pend_lsb_q, 3'b000};
        half_sh = lsu_rdata_i >> {pend_lsb_q[1], 4'b0000};
        ld_byte = byte_sh[7:0];
        ld_half = half_sh[15:0];
        ld_data = lsu_rdata_i;
        unique case (pend_f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = lsu_rdata_i;
        endcase
    end

    // Select the write for next cycle: completing load or accepted non-load
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = wb_rd_i;
        wr_data = wb_result_i;
        retire  = 1'b0;
        if (load_done) begin
            wr_en   = pend_we_q && (pend_rd_q != 5'd0);
            wr_rd   = pend_rd_q;
            wr_data = ld_data;
            retire  = 1'b1;
        end else if (accept && !wb_is_load_i) begin
            wr_en   = wb_reg_write_i && (wb_rd_i != 5'd0);
            retire  = 1'b1;
        end
    end

    // Register-file write port; address and data hold when not writing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_o        <= 5'd0;
            rd_din_o    <= '0;
            reg_write_o <= 1'b0;
        end else begin
            reg_write_o <= wr_en;
            if (wr_en) begin
                rd_o     <= wr_rd;
                rd_din_o <= wr_data;
            end
        end
    end

    // Status: retire count, timeout pulse and sticky spurious flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retire_cnt_o <= 32'd0;
            load_err_o   <= 1'b0;
            spurious_o   <= 1'b0;
        end else begin
            if (retire) retire_cnt_o <= retire_cnt_o + 32'd1;
            load_err_o <= timeout;
            if (state_q == IDLE && lsu_rvalid_i) spurious_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, hand sequences and randomized traffic
// checked against a spec-level reference model of wb_stage.
module tb_wb_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_rd = '0;
    logic        wb_reg_write = 1'b0;
    logic [31:0] wb_result = '0;
    logic        wb_is_load = 1'b0;
    logic [2:0]  wb_funct3 = '0;
    logic [1:0]  wb_addr_lsb = '0;
    logic        lsu_rvalid = 1'b0;
    logic [31:0] lsu_rdata = '0;
    logic [4:0]  rd;
    logic [31:0] rd_din;
    logic        reg_write;
    logic        load_pending;
    logic [4:0]  load_rd;
    logic        load_err;
    logic        spurious;
    logic [31:0] retire_cnt;

    wb_stage #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wb_valid_i     (wb_valid),
        .wb_ready_o     (wb_ready),
        .wb_rd_i        (wb_rd),
        .wb_reg_write_i (wb_reg_write),
        .wb_result_i    (wb_result),
        .wb_is_load_i   (wb_is_load),
        .wb_funct3_i    (wb_funct3),
        .wb_addr_lsb_i  (wb_addr_lsb),
        .lsu_rvalid_i   (lsu_rvalid),
        .lsu_rdata_i    (lsu_rdata),
        .rd_o           (rd),
        .rd_din_o       (rd_din),
        .reg_write_o    (reg_write),
        .load_pending_o (load_pending),
        .load_rd_o      (load_rd),
        .load_err_o     (load_err),
        .spurious_o     (spurious),
        .retire_cnt_o   (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_retire = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_din = 0;
    logic        m_spur = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference load extraction, straight from the load-type rules
    function automatic logic [31:0] ref_load(input int f3, input int lsb,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * lsb)) & 32'hFF;
        h = (w >> (16 * (lsb / 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return w;
        endcase
    endfunction

    task automatic chk_regs(input string nm, input logic exp_we,
                            input logic [4:0] erd, input logic [31:0] edin);
        if (exp_we) begin
            m_rd  = erd;
            m_din = edin;
        end
        chk({nm, ".we"}, 32'(reg_write), 32'(exp_we));
        chk({nm, ".rd"}, 32'(rd), 32'(m_rd));
        chk({nm, ".din"}, rd_din, m_din);
        chk({nm, ".retire"}, retire_cnt, m_retire);
        chk({nm, ".spur"}, 32'(spurious), 32'(m_spur));
        chk({nm, ".err"}, 32'(load_err), 32'd0);
    endtask

    task automatic issue_alu(input string nm, input logic [4:0] r,
                             input logic we, input logic [31:0] res);
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_is_load   = 1'b0;
        wb_rd        = r;
        wb_reg_write = we;
        wb_result    = res;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        m_retire++;
        chk_regs(nm, we && r != 0, r, res);
        chk({nm, ".ready"}, 32'(wb_ready), 32'd1);
    endtask

    task automatic issue_load(input string nm, input logic [4:0] r,
                              input logic we, input logic [2:0] f3,
                              input logic [1:0] lsb, input logic [31:0] w,
                              input int dly, input logic [31:0] exp);
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_is_load   = 1'b1;
        wb_rd        = r;
        wb_reg_write = we;
        wb_funct3    = f3;
        wb_addr_lsb  = lsb;
        wb_result    = $urandom;
        @(posedge clk);
        #1;
        wb_valid   = 1'b0;
        wb_is_load = 1'b0;
        chk_regs({nm, ".acc"}, 1'b0, 0, 0);
        chk({nm, ".ready"}, 32'(wb_ready), 32'd0);
        chk({nm, ".pend"}, 32'(load_pending), 32'd1);
        chk({nm, ".lrd"}, 32'(load_rd), 32'(r));
        for (int i = 0; i < dly; i++) begin
            @(posedge clk);
            #1;
            chk_regs({nm, ".wait"}, 1'b0, 0, 0);
            chk({nm, ".wpend"}, 32'(load_pending), 32'd1);
        end
        @(negedge clk);
        lsu_rvalid = 1'b1;
        lsu_rdata  = w;
        @(posedge clk);
        #1;
        lsu_rvalid = 1'b0;
        m_retire++;
        chk_regs({nm, ".rsp"}, we && r != 0, r, exp);
        chk({nm, ".rready"}, 32'(wb_ready), 32'd1);
        chk({nm, ".rlrd"}, 32'(load_rd), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 2'd3, 32'h80AB_CDEF, 32'hFFFF_FF80};
        vecs[1]  = '{3'b101, 2'd2, 32'h80AB_CDEF, 32'h0000_80AB};
        vecs[2]  = '{3'b001, 2'd0, 32'h80AB_CDEF, 32'hFFFF_CDEF};
        vecs[3]  = '{3'b100, 2'd0, 32'h80AB_CDEF, 32'h0000_00EF};
        vecs[4]  = '{3'b000, 2'd1, 32'h80AB_CDEF, 32'hFFFF_FFCD};
        vecs[5]  = '{3'b100, 2'd2, 32'h80AB_CDEF, 32'h0000_00AB};
        vecs[6]  = '{3'b001, 2'd1, 32'h80AB_CDEF, 32'hFFFF_CDEF};
        vecs[7]  = '{3'b101, 2'd3, 32'h80AB_CDEF, 32'h0000_80AB};
        vecs[8]  = '{3'b010, 2'd2, 32'h80AB_CDEF, 32'h80AB_CDEF};
        vecs[9]  = '{3'b011, 2'd1, 32'h80AB_CDEF, 32'h80AB_CDEF};
        vecs[10] = '{3'b110, 2'd3, 32'h80AB_CDEF, 32'h80AB_CDEF};
        vecs[11] = '{3'b000, 2'd2, 32'h1234_5678, 32'h0000_0034};
        vecs[12] = '{3'b001, 2'd2, 32'h1234_5678, 32'h0000_1234};
        vecs[13] = '{3'b111, 2'd0, 32'h1234_5678, 32'h1234_5678};

        #12;
        chk("rst.ready", 32'(wb_ready), 32'd1);
        chk("rst.pend", 32'(load_pending), 32'd0);
        chk_regs("rst", 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue_alu("alu5", 5'd5, 1'b1, 32'h1234_5678);
        issue_alu("alu_r0", 5'd0, 1'b1, 32'hDEAD_BEEF);
        issue_alu("alu_nowe", 5'd3, 1'b0, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++)
            issue_alu("b2b", 5'(i + 10), 1'b1, 32'(i * 32'h0101_0101));

        issue_load("lb_plan", 5'd7, 1'b1, 3'b000, 2'd3, 32'h80AB_CDEF,
                   3, 32'hFFFF_FF80);

        for (int i = 0; i < 14; i++)
            issue_load($sformatf("vec%0d", i), 5'd7, 1'b1, vecs[i].f3,
                       vecs[i].lsb, vecs[i].rdata, i % 3, vecs[i].exp);

        issue_load("ld_r0", 5'd0, 1'b1, 3'b010, 2'd0, 32'hCAFE_0000,
                   0, 32'hCAFE_0000);

        // Held valid during LOAD_WAIT is ignored, then accepted after rsp
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_is_load   = 1'b1;
        wb_rd        = 5'd20;
        wb_reg_write = 1'b1;
        wb_funct3    = 3'b010;
        wb_addr_lsb  = 2'd0;
        @(posedge clk);
        #1;
        wb_is_load = 1'b0;
        wb_rd      = 5'd9;
        wb_result  = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_regs("hold.wait", 1'b0, 0, 0);
            chk("hold.ready", 32'(wb_ready), 32'd0);
        end
        @(negedge clk);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h0F0F_1234;
        @(posedge clk);
        #1;
        lsu_rvalid = 1'b0;
        m_retire++;
        chk_regs("hold.rsp", 1'b1, 5'd20, 32'h0F0F_1234);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        m_retire++;
        chk_regs("hold.next", 1'b1, 5'd9, 32'h5555_AAAA);

        // Spurious response in IDLE
        @(negedge clk);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        lsu_rvalid = 1'b0;
        m_spur = 1'b1;
        chk_regs("spur", 1'b0, 0, 0);
        issue_alu("spur.after", 5'd1, 1'b1, 32'h1);

        for (int t = 0; t < 80; t++) begin
            logic [4:0]  r;
            logic        we;
            logic [31:0] w;
            int          f3;
            int          lsb;
            r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            we = ($urandom_range(0, 3) != 0);
            w  = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                issue_alu("rnd.alu", r, we, w);
            end else begin
                f3  = $urandom_range(0, 7);
                lsb = $urandom_range(0, 3);
                issue_load("rnd.ld", r, we, 3'(f3), 2'(lsb), w,
                           $urandom_range(0, TMO), ref_load(f3, lsb, w));
            end
        end

`ifdef WB_LOAD_TIMEOUT_EN
        // Response arriving exactly at the limit wins over the timeout
        issue_load("tmo.edge", 5'd4, 1'b1, 3'b010, 2'd0, 32'h7777_0001,
                   TMO, 32'h7777_0001);
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_is_load   = 1'b1;
        wb_rd        = 5'd6;
        wb_reg_write = 1'b1;
        @(posedge clk);
        #1;
        wb_valid   = 1'b0;
        wb_is_load = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk);
            #1;
            chk_regs("tmo.wait", 1'b0, 0, 0);
            chk("tmo.pend", 32'(load_pending), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("tmo.err", 32'(load_err), 32'd1);
        chk("tmo.we", 32'(reg_write), 32'd0);
        chk("tmo.ready", 32'(wb_ready), 32'd1);
        chk("tmo.retire", retire_cnt, m_retire);
        @(posedge clk);
        #1;
        chk_regs("tmo.after", 1'b0, 0, 0);
`endif

        // Reset in the middle of LOAD_WAIT drops the load
        @(negedge clk);
        wb_valid     = 1'b1;
        wb_is_load   = 1'b1;
        wb_rd        = 5'd12;
        wb_reg_write = 1'b1;
        @(posedge clk);
        #1;
        wb_valid   = 1'b0;
        wb_is_load = 1'b0;
        chk("mid.pend", 32'(load_pending), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_retire = 0;
        m_rd     = 0;
        m_din    = 0;
        m_spur   = 0;
        chk_regs("mid.rst", 1'b0, 0, 0);
        chk("mid.ready", 32'(wb_ready), 32'd1);
        chk("mid.pend0", 32'(load_pending), 32'd0);
        chk("mid.lrd", 32'(load_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_regs("mid.post", 1'b0, 0, 0);
        issue_alu("mid.alu", 5'd2, 1'b1, 32'hA5A5_5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
